// File: rtl/mixer_tdm_core.sv
// mixer_tdm_core: stereo mixer that shares one Q-format multiplier across all
// mono inputs (per-channel gain, mute and clamped pan, then master gain).
module mixer_tdm_core #(
  parameter int unsigned AUDIO_WIDTH_P    = 24,
  parameter int unsigned NR_OF_CHANNELS_P = 8,
  parameter int unsigned Q_BITS_P         = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] channel_data,
  input  logic                                      channel_valid,
  output logic                                      channel_ready,
  output logic [AUDIO_WIDTH_P-1:0]                  out_left,
  output logic [AUDIO_WIDTH_P-1:0]                  out_right,
  output logic                                      out_valid,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] cr_mix_channel_gain,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] cr_mix_channel_pan,
  input  logic [NR_OF_CHANNELS_P-1:0]               cr_mix_channel_mute,
  input  logic [AUDIO_WIDTH_P-1:0]                  cr_mix_output_gain,
  input  logic                                      cmd_mix_clr_clip,
  output logic [1:0]                                sr_mix_out_clip,
  output logic [NR_OF_CHANNELS_P-1:0]               sr_mix_channel_clip
);

  localparam int unsigned W  = AUDIO_WIDTH_P;
  localparam int unsigned N  = NR_OF_CHANNELS_P;
  localparam int unsigned Q  = Q_BITS_P;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = W + $clog2(N) + 1;
  localparam int unsigned PW = 2 * W;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] Q_ONE   = W'(1) << Q;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CH_GAIN  = 3'd1,
    CH_PAN   = 3'd2,
    MASTER_L = 3'd3,
    MASTER_R = 3'd4
  } state_t;

  // Q multiply with floor shift; returns {ovf, saturated W-bit result}
  function automatic logic [W:0] q_mul(input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shf;
    logic                 ovf;
    logic [W-1:0]         res;
    prod = PW'(a) * PW'(b);
    shf  = prod >>> Q;
    ovf  = !((&shf[PW-1:W-1]) || (~|shf[PW-1:W-1]));
    if (!ovf)           res = shf[W-1:0];
    else if (shf[PW-1]) res = SAT_MIN;
    else                res = SAT_MAX;
    return {ovf, res};
  endfunction

  // Saturate a wide accumulator down to W bits; returns {ovf, result}
  function automatic logic [W:0] acc_sat(input logic signed [AW-1:0] a);
    logic         ovf;
    logic [W-1:0] res;
    ovf = !((&a[AW-1:W-1]) || (~|a[AW-1:W-1]));
    if (!ovf)         res = a[W-1:0];
    else if (a[AW-1]) res = SAT_MIN;
    else              res = SAT_MAX;
    return {ovf, res};
  endfunction

  state_t                state_q;
  state_t                state_d;
  logic                  ready_d;
  logic                  hs_c;
  logic                  last_c;

  logic signed [W-1:0]   data_s [N];
  logic signed [W-1:0]   gain_s [N];
  logic signed [W-1:0]   pan_s  [N];
  logic [N-1:0]          mute_s;
  logic signed [W-1:0]   out_gain_s;

  logic [IW-1:0]         idx_q;
  logic signed [W-1:0]   g_q;
  logic signed [AW-1:0]  acc_l_q;
  logic signed [AW-1:0]  acc_r_q;

  logic signed [W-1:0]   mul_a_c;
  logic signed [W-1:0]   mul_b_c;
  logic signed [W-1:0]   mul_res_c;
  logic                  mul_ovf_c;
  logic signed [W-1:0]   pan_c;
  logic signed [AW-1:0]  acc_sel_c;
  logic signed [W-1:0]   acc_sat_c;
  logic                  acc_ovf_c;
  logic signed [W:0]     r_c;
  logic [N-1:0]          ch_set_c;
  logic [1:0]            out_set_c;

  assign hs_c   = (state_q == IDLE) && channel_valid && channel_ready;
  assign last_c = (idx_q == IW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and ready decode
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (channel_valid && channel_ready) begin
          state_d = CH_GAIN;
          ready_d = 1'b0;
        end
      end
      CH_GAIN:  state_d = CH_PAN;
      CH_PAN:   state_d = last_c ? MASTER_L : CH_GAIN;
      MASTER_L: state_d = MASTER_R;
      MASTER_R: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Shared multiplier operand mux, pan clamp and accumulator saturation
  always_comb begin
    mul_a_c   = '0;
    mul_b_c   = '0;
    pan_c     = pan_s[idx_q];
    acc_sel_c = (state_q == MASTER_R) ? acc_r_q : acc_l_q;
    {acc_ovf_c, acc_sat_c} = acc_sat(acc_sel_c);
    if (pan_s[idx_q][W-1])        pan_c = '0;
    else if (pan_s[idx_q] > Q_ONE) pan_c = Q_ONE;
    case (state_q)
      CH_GAIN: begin
        mul_a_c = data_s[idx_q];
        mul_b_c = gain_s[idx_q];
      end
      CH_PAN: begin
        mul_a_c = g_q;
        mul_b_c = pan_c;
      end
      MASTER_L, MASTER_R: begin
        mul_a_c = acc_sat_c;
        mul_b_c = out_gain_s;
      end
      default: ;
    endcase
    {mul_ovf_c, mul_res_c} = q_mul(mul_a_c, mul_b_c);
    r_c = (W+1)'(g_q) - (W+1)'(mul_res_c);
  end

  // Clip-flag set requests for this cycle
  always_comb begin
    ch_set_c  = '0;
    out_set_c = '0;
    if ((state_q == CH_GAIN) && mul_ovf_c && !mute_s[idx_q]) ch_set_c[idx_q] = 1'b1;
    if (state_q == MASTER_L) out_set_c[0] = acc_ovf_c | mul_ovf_c;
    if (state_q == MASTER_R) out_set_c[1] = acc_ovf_c | mul_ovf_c;
  end

  // Frame snapshot of samples and configuration at the handshake
  always_ff @(posedge clk) begin
    if (hs_c) begin
      for (int i = 0; i < N; i++) begin
        data_s[i] <= channel_data[i*W +: W];
        gain_s[i] <= cr_mix_channel_gain[i*W +: W];
        pan_s[i]  <= cr_mix_channel_pan[i*W +: W];
      end
      mute_s     <= cr_mix_channel_mute;
      out_gain_s <= cr_mix_output_gain;
    end
  end

  // Per-channel datapath, accumulation and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      g_q           <= '0;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      channel_ready <= 1'b0;
      out_left      <= '0;
      out_right     <= '0;
      out_valid     <= 1'b0;
    end else begin
      channel_ready <= ready_d;
      out_valid     <= (state_q == MASTER_R);
      case (state_q)
        IDLE: begin
          if (hs_c) begin
            idx_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
          end
        end
        CH_GAIN:  g_q <= mute_s[idx_q] ? '0 : mul_res_c;
        CH_PAN: begin
          acc_l_q <= acc_l_q + AW'(mul_res_c);
          acc_r_q <= acc_r_q + AW'(r_c);
          if (!last_c) idx_q <= idx_q + IW'(1);
        end
        MASTER_L: out_left  <= mul_res_c;
        MASTER_R: out_right <= mul_res_c;
        default: ;
      endcase
    end
  end

  // Sticky clip flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_mix_channel_clip <= '0;
      sr_mix_out_clip     <= '0;
    end else begin
      sr_mix_channel_clip <= (sr_mix_channel_clip & ~{N{cmd_mix_clr_clip}}) | ch_set_c;
      sr_mix_out_clip     <= (sr_mix_out_clip & ~{2{cmd_mix_clr_clip}}) | out_set_c;
    end
  end

endmodule

// File: tb/tb_mixer_tdm_core.sv
// tb_mixer_tdm_core: directed table, corner sequences and randomized frames
// against an arithmetic reference model of the mixer.
module tb_mixer_tdm_core;

  localparam int W   = 24;
  localparam int N   = 4;
  localparam int Q   = 16;
  localparam int LAT = 2 * N + 2;

  typedef struct packed {
    logic [N-1:0][W-1:0] data;
    logic [N-1:0][W-1:0] gain;
    logic [N-1:0][W-1:0] pan;
    logic [N-1:0]        mute;
    logic [W-1:0]        og;
    logic [W-1:0]        exp_l;
    logic [W-1:0]        exp_r;
    logic [N-1:0]        exp_ch;
    logic [1:0]          exp_out;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [N*W-1:0]   channel_data;
  logic             channel_valid;
  logic             channel_ready;
  logic [W-1:0]     out_left;
  logic [W-1:0]     out_right;
  logic             out_valid;
  logic [N*W-1:0]   cr_gain;
  logic [N*W-1:0]   cr_pan;
  logic [N-1:0]     cr_mute;
  logic [W-1:0]     cr_og;
  logic             clr;
  logic [1:0]       sr_out_clip;
  logic [N-1:0]     sr_ch_clip;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int hs_last = 0;
  int hs_prev = 0;
  int ov_count = 0;
  logic [N-1:0] st_ch;
  logic [1:0]   st_out;
  vec_t tab [9];
  vec_t base;
  vec_t v;
  vec_t v2;

  mixer_tdm_core #(.AUDIO_WIDTH_P(W), .NR_OF_CHANNELS_P(N), .Q_BITS_P(Q)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .channel_data        (channel_data),
    .channel_valid       (channel_valid),
    .channel_ready       (channel_ready),
    .out_left            (out_left),
    .out_right           (out_right),
    .out_valid           (out_valid),
    .cr_mix_channel_gain (cr_gain),
    .cr_mix_channel_pan  (cr_pan),
    .cr_mix_channel_mute (cr_mute),
    .cr_mix_output_gain  (cr_og),
    .cmd_mix_clr_clip    (clr),
    .sr_mix_out_clip     (sr_out_clip),
    .sr_mix_channel_clip (sr_ch_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and handshake log
  always @(posedge clk) begin
    cyc++;
    if (rst_n && channel_valid && channel_ready) begin
      hs_prev = hs_last;
      hs_last = cyc;
      hs_count++;
    end
  end

  always @(negedge clk) if (out_valid) ov_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: spec arithmetic on plain integers
  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint sat_w(input longint val, output bit o);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    o  = (val > hi) || (val < lo);
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

  function automatic longint qm(input longint a, input longint b, output bit o);
    return sat_w((a * b) >>> Q, o);
  endfunction

  function automatic vec_t model(input vec_t vi);
    vec_t   r;
    longint al, ar, g, p, l, s, o;
    bit     ov, ov2;
    r  = vi;
    al = 0;
    ar = 0;
    r.exp_ch  = '0;
    r.exp_out = '0;
    for (int i = 0; i < N; i++) begin
      g = qm(sx(vi.data[i]), sx(vi.gain[i]), ov);
      if (vi.mute[i]) g = 0;
      else if (ov) r.exp_ch[i] = 1'b1;
      p = sx(vi.pan[i]);
      if (p < 0) p = 0;
      if (p > (longint'(1) <<< Q)) p = longint'(1) <<< Q;
      l  = qm(g, p, ov);
      al = al + l;
      ar = ar + (g - l);
    end
    s = sat_w(al, ov);
    o = qm(s, sx(vi.og), ov2);
    r.exp_l      = W'(o);
    r.exp_out[0] = ov | ov2;
    s = sat_w(ar, ov);
    o = qm(s, sx(vi.og), ov2);
    r.exp_r      = W'(o);
    r.exp_out[1] = ov | ov2;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) r.data[i] = W'($urandom);
      else r.data[i] = W'($urandom_range(0, 2000000)) - W'(1000000);
      if ($urandom_range(0, 5) == 0) r.gain[i] = W'($urandom);
      else r.gain[i] = W'($urandom_range(0, 262144)) - W'(131072);
      r.pan[i]  = W'($urandom_range(0, 98304)) - W'(16384);
      r.mute[i] = ($urandom_range(0, 4) == 0);
    end
    r.og = W'($urandom_range(0, 196608)) - W'(65536);
    return r;
  endfunction

  task automatic apply_vec(input vec_t vi);
    channel_data = vi.data;
    cr_gain      = vi.gain;
    cr_pan       = vi.pan;
    cr_mute      = vi.mute;
    cr_og        = vi.og;
  endtask

  // Raise valid and wait (bounded) for the handshake edge
  task automatic wait_hs(input string tag, output bit got);
    int n0;
    n0  = hs_count;
    got = 1'b0;
    channel_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (hs_count != n0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s handshake: none within 40 cycles", tag);
      channel_valid = 1'b0;
    end
  endtask

  // One frame: entered and left at a negedge; checks latency, data, flags
  task automatic do_frame(input vec_t vi, input bit hold, input int change_at,
                          input logic [N*W-1:0] gain2, input int clr_at, input string tag);
    bit got;
    int lat;
    apply_vec(vi);
    wait_hs(tag, got);
    if (!got) return;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) channel_valid = 1'b0;
      if (k == change_at - 1) cr_gain = gain2;
      if (k == clr_at - 1) clr = 1'b1;
      else if (k == clr_at) clr = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    clr = 1'b0;
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " out_left"}, 32'(out_left), 32'(vi.exp_l));
    chk({tag, " out_right"}, 32'(out_right), 32'(vi.exp_r));
    chk({tag, " ch_clip"}, 32'(sr_ch_clip), 32'(vi.exp_ch));
    chk({tag, " out_clip"}, 32'(sr_out_clip), 32'(vi.exp_out));
    st_ch  = vi.exp_ch;
    st_out = vi.exp_out;
    if (!hold) begin
      @(negedge clk);
      chk({tag, " valid width"}, 32'(out_valid), 32'd0);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    st_ch  = '0;
    st_out = '0;
    chk("clear ch_clip", 32'(sr_ch_clip), 32'd0);
    chk("clear out_clip", 32'(sr_out_clip), 32'd0);
  endtask

  initial begin
    bit got;
    int ov0;
    rst_n = 1'b0;
    channel_valid = 1'b0;
    clr = 1'b0;
    channel_data = '0;
    cr_gain = '0;
    cr_pan = '0;
    cr_mute = '0;
    cr_og = '0;
    st_ch = '0;
    st_out = '0;

    // Directed table
    base = '0;
    for (int i = 0; i < N; i++) begin
      base.gain[i] = 24'h010000;
      base.pan[i]  = 24'h008000;
    end
    base.og = 24'h010000;

    tab[0] = base;
    tab[0].data[0] = 24'd1000;
    tab[0].data[1] = 24'd2000;
    tab[0].data[2] = -24'sd500;
    tab[0].exp_l = 24'd1250;
    tab[0].exp_r = 24'd1250;

    tab[1] = tab[0];
    tab[1].og = 24'hFF0000;
    tab[1].exp_l = 24'hFFFB1E;
    tab[1].exp_r = 24'hFFFB1E;

    tab[2] = base;
    tab[2].data[0] = 24'd4000;
    tab[2].pan[0]  = 24'h010000;
    for (int i = 1; i < N; i++) begin
      tab[2].mute[i] = 1'b1;
      tab[2].data[i] = 24'h7FFFFF;
      tab[2].gain[i] = 24'h7FFFFF;
    end
    tab[2].exp_l = 24'd4000;
    tab[2].exp_r = 24'd0;

    tab[3] = base;
    tab[3].mute    = 4'b1101;
    tab[3].data[1] = 24'h7FFFFF;
    tab[3].gain[1] = 24'h020000;
    tab[3].exp_l   = 24'd4194303;
    tab[3].exp_r   = 24'd4194304;
    tab[3].exp_ch  = 4'b0010;

    tab[4] = base;
    for (int i = 0; i < N; i++) begin
      tab[4].data[i] = 24'h600000;
      tab[4].pan[i]  = 24'h010000;
    end
    tab[4].exp_l   = 24'h7FFFFF;
    tab[4].exp_r   = 24'd0;
    tab[4].exp_out = 2'b01;

    tab[5] = tab[4];
    tab[5].pan[3] = 24'h020000;

    tab[6] = tab[4];
    tab[6].pan[3] = 24'hFFFFFF;
    tab[6].exp_r  = 24'h600000;

    tab[7] = base;
    for (int i = 0; i < N; i++) begin
      tab[7].data[i] = 24'hA00000;
      tab[7].pan[i]  = 24'h000000;
    end
    tab[7].exp_l   = 24'd0;
    tab[7].exp_r   = 24'h800000;
    tab[7].exp_out = 2'b10;

    tab[8] = base;
    tab[8].data[0] = 24'h800000;
    tab[8].gain[0] = 24'hFF0000;
    tab[8].exp_l   = 24'd4194303;
    tab[8].exp_r   = 24'd4194304;
    tab[8].exp_ch  = 4'b0001;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(channel_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_left", 32'(out_left), 32'd0);
    chk("reset out_right", 32'(out_right), 32'd0);
    chk("reset clips", 32'({sr_out_clip, sr_ch_clip}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", 32'(channel_ready), 32'd1);

    for (int t = 0; t < 9; t++) begin
      pulse_clr();
      do_frame(tab[t], 1'b0, 0, '0, 0, $sformatf("table%0d", t));
    end

    // Clear and set in the same cycle: set wins, older flags go
    do_frame(tab[3], 1'b0, 0, '0, 3, "clr_vs_set");

    // Config change mid-frame, then back-to-back frames
    pulse_clr();
    v = tab[0];
    v2 = tab[0];
    for (int i = 0; i < N; i++) v2.gain[i] = 24'h020000;
    v2.exp_l = 24'd2500;
    v2.exp_r = 24'd2500;
    do_frame(v, 1'b1, 3, v2.gain, 0, "snapshot");
    do_frame(v2, 1'b0, 0, '0, 0, "new_cfg");
    chk("b2b spacing", 32'(hs_last - hs_prev), 32'(2 * N + 3));

    // Reset mid-frame aborts it
    pulse_clr();
    do_frame(tab[6], 1'b0, 0, '0, 0, "pre_reset");
    apply_vec(tab[0]);
    wait_hs("abort", got);
    @(negedge clk);
    channel_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    ov0 = ov_count;
    @(negedge clk);
    chk("abort out_left", 32'(out_left), 32'd0);
    chk("abort out_right", 32'(out_right), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort ready", 32'(channel_ready), 32'd0);
    chk("abort clips", 32'({sr_out_clip, sr_ch_clip}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready release", 32'(channel_ready), 32'd1);
    repeat (15) @(negedge clk);
    chk("abort no out_valid", 32'(ov_count - ov0), 32'd0);
    st_ch = '0;
    st_out = '0;
    do_frame(tab[0], 1'b0, 0, '0, 0, "after_reset");

    // Randomized frames against the model with sticky flag tracking
    for (int n = 0; n < 40; n++) begin
      v = model(rand_vec());
      if ($urandom_range(0, 3) == 0) pulse_clr();
      v.exp_ch  = st_ch | v.exp_ch;
      v.exp_out = st_out | v.exp_out;
      do_frame(v, 1'b0, 0, '0, 0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixer_tdm_core.md
Name: mixer_tdm_core

Overview:
- Successor stereo mixer core that time-multiplexes one internal Q-format multiplier across NR_OF_CHANNELS_P mono inputs.
- Per channel: gain, mute, clamped pan. Then a wide stereo accumulation and master gain with saturation.
- Deterministic latency. Configuration is snapshotted per frame. Clip flags are sticky and software-clearable.
- Sits between the audio input FIFOs and the I2S/DAC egress.

Parameters:
AUDIO_WIDTH_P, 24, sample/coefficient width W (signed two's complement)
NR_OF_CHANNELS_P, 8, number of mono input channels N (>=1)
Q_BITS_P, 16, fractional bits of all gain/pan coefficients (1.0 = 2^Q)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
channel_data  in  N*W  signed samples, one per channel
channel_valid  in  1  frame valid
channel_ready  out  1  frame accepted when valid&&ready
out_left  out  W  signed mixed left sample
out_right  out  W  signed mixed right sample
out_valid  out  1  one-cycle pulse per frame
cr_mix_channel_gain  in  N*W  signed Q gain per channel
cr_mix_channel_pan  in  N*W  signed Q pan (left weight) per channel
cr_mix_channel_mute  in  N  1 = channel contributes zero
cr_mix_output_gain  in  W  signed Q master gain
cmd_mix_clr_clip  in  1  pulse, clears all clip flags
sr_mix_out_clip  out  2  sticky clip, [0]=left, [1]=right
sr_mix_channel_clip  out  N  sticky per-channel gain clip

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE. All outputs are 0, including channel_ready.
  - channel_ready rises at the first edge after rst_n is high.
  - Asserting reset mid-frame aborts the frame. No out_valid is produced.
- Q multiply: p = (a*b) >>> Q_BITS_P (arithmetic shift, floor), then saturate to [-2^(W-1), 2^(W-1)-1]. An ovf bit flags saturation.
- FSM states: IDLE, CH_GAIN, CH_PAN, MASTER_L, MASTER_R.
- IDLE:
  - channel_ready=1.
  - On handshake (edge 0): capture channel_data, gain, pan, mute and output_gain into snapshot registers. Clear both accumulators. Set idx=0, ready=0, then go to CH_GAIN.
  - Register changes after edge 0 do not affect the frame.
- CH_GAIN (1 cycle):
  - g_r <= sat(x[idx]*gain[idx]).
  - If ovf and not muted, set sr_mix_channel_clip[idx].
  - If muted, g_r <= 0.
  - Then go to CH_PAN.
- CH_PAN (1 cycle):
  - pan_c = pan clamped to [0, 2^Q]; negative values become 0.
  - l = sat(g_r*pan_c); r = g_r - l.
  - acc_l += l; acc_r += r.
  - Accumulators are signed, W+$clog2(N)+1 bits, and never wrap.
  - If idx==N-1, go to MASTER_L; else idx++ and go to CH_GAIN.
- MASTER_L:
  - s = saturate acc_l to W bits.
  - out_left <= sat(s*output_gain).
  - Set sr_mix_out_clip[0] if either saturation occurred.
- MASTER_R:
  - Same as MASTER_L for right: out_right, sr_mix_out_clip[1].
  - out_valid <= 1 for one cycle, channel_ready <= 1, then go to IDLE.
- Latency and throughput:
  - out_valid is first seen high after edge 2N+2, counted from the handshake edge.
  - out_left/out_right hold their values until the next frame's MASTER_L/MASTER_R.
  - Next handshake at the earliest on edge 2N+3, giving 2N+3 cycles per frame.
- Clip flags:
  - Sticky until cmd_mix_clr_clip.
  - A set in the same cycle as a clear wins (flag ends at 1).
- channel_valid low during IDLE keeps the core idle.
- There is no egress backpressure. The consumer must accept out_valid.

Test Plan (W=24, Q=16, N=4; 1.0=0x010000, 0.5=0x008000):
1. Gains 1.0, pans 0.5, master 1.0, data {1000,2000,-500,0} -> out_left=1250, out_right=1250. out_valid 10 edges after handshake, one cycle wide. No clip flags.
2. ch0 data 4000, pan 1.0; ch1..3 mute=1 with data 0x7FFFFF, gain 0x7FFFFF -> out_left=4000, out_right=0, sr_mix_channel_clip=0.
3. ch1 data 0x7FFFFF, gain 2.0, pan 0.5; others muted -> sr_mix_channel_clip=4'b0010, out_left=4194303, out_right=4194304. Then a cmd_mix_clr_clip pulse -> flags 0.
4. All channels data 0x600000, gain 1.0, pan 1.0; also pan 0x020000 and pan -1 on ch3 in a second frame (clamp check) -> frame 1: out_left=0x7FFFFF, out_right=0, sr_mix_out_clip=2'b01. Frame 2 with ch3 pan -1: ch3 contributes only to right.
5. Change cr_mix_channel_gain at edge 3 of a frame -> output matches pre-change values. Next frame uses new values. Back-to-back valid -> handshakes exactly 11 edges apart.
6. Drive rst_n low at edge 5 of a frame -> no out_valid, all outputs 0. channel_ready=1 one edge after release. The next frame gives the correct result.
